// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - up/down step counter with programmable inclusive limit, wrap or saturate
module wrap_counter #(
  parameter int WIDTH     = 10,
  parameter bit EDGE_MODE = 1'b1,
  parameter bit SATURATE  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic             step_q;
  logic             adv;
  logic [WIDTH-1:0] next_count;
  logic             next_wrap;

  // step_q resets high so a step held across reset release is not seen as an edge
  assign adv = EDGE_MODE ? (step & ~step_q) : step;

  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    if (load) begin
      next_count = (load_value > max) ? max : load_value;
    end else if (adv) begin
      if (up) begin
        if (count >= max) begin
          next_count = SATURATE ? max : ZERO;
          next_wrap  = 1'b1;
        end else begin
          next_count = count + ONE;
        end
      end else begin
        if (count == ZERO) begin
          next_count = SATURATE ? ZERO : max;
          next_wrap  = 1'b1;
        end else if (count > max) begin
          // max was lowered below count: clamp without flagging a limit event
          next_count = max;
        end else begin
          next_count = count - ONE;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= ZERO;
      wrap   <= 1'b0;
      step_q <= 1'b1;
    end else begin
      count  <= next_count;
      wrap   <= next_wrap;
      step_q <= step;
    end
  end

  assign at_max = (count == max);

endmodule

// File: tb/tb_wrap_counter.sv
// tb/tb_wrap_counter.sv - directed self-checking bench for wrap_counter
module tb_wrap_counter;

  logic clock;
  logic reset;
  logic up;

  logic       step_d, load_d, wrap_d, at_max_d;
  logic [9:0] lv_d, max_d, count_d;
  logic       step_l, load_l, wrap_l, at_max_l;
  logic [9:0] lv_l, max_l, count_l;
  logic       step_s, load_s, wrap_s, at_max_s;
  logic [9:0] lv_s, max_s, count_s;
  logic        step_w, load_w, wrap_w, at_max_w;
  logic [15:0] lv_w, max_w, count_w;

  int tests = 0;
  int fails = 0;

  wrap_counter u_d (
    .clock(clock), .reset(reset), .step(step_d), .up(up), .load(load_d),
    .load_value(lv_d), .max(max_d), .count(count_d), .wrap(wrap_d), .at_max(at_max_d)
  );

  wrap_counter #(.WIDTH(10), .EDGE_MODE(1'b0), .SATURATE(1'b0)) u_l (
    .clock(clock), .reset(reset), .step(step_l), .up(up), .load(load_l),
    .load_value(lv_l), .max(max_l), .count(count_l), .wrap(wrap_l), .at_max(at_max_l)
  );

  wrap_counter #(.WIDTH(10), .EDGE_MODE(1'b1), .SATURATE(1'b1)) u_s (
    .clock(clock), .reset(reset), .step(step_s), .up(up), .load(load_s),
    .load_value(lv_s), .max(max_s), .count(count_s), .wrap(wrap_s), .at_max(at_max_s)
  );

  wrap_counter #(.WIDTH(16), .EDGE_MODE(1'b1), .SATURATE(1'b0)) u_w (
    .clock(clock), .reset(reset), .step(step_w), .up(up), .load(load_w),
    .load_value(lv_w), .max(max_w), .count(count_w), .wrap(wrap_w), .at_max(at_max_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int exp30 [4];
    exp30 = '{1, 2, 3, 0};

    reset = 1'b1; up = 1'b1;
    step_d = 0; load_d = 0; lv_d = 0; max_d = 10'd3;
    step_l = 0; load_l = 0; lv_l = 0; max_l = 10'd20;
    step_s = 0; load_s = 0; lv_s = 0; max_s = 10'd5;
    step_w = 0; load_w = 0; lv_w = 0; max_w = 16'hFFFF;
    tick();
    tick();
    check("rst_count_d", count_d, 0);
    check("rst_wrap_d", wrap_d, 0);
    check("rst_at_max_d", at_max_d, 0);
    check("rst_count_w", count_w, 0);
    reset = 1'b0;
    tick();

    // four isolated pulses with max=3
    for (int i = 0; i < 4; i++) begin
      step_d = 1'b1;
      tick();
      check("seq_count", count_d, exp30[i]);
      check("seq_wrap", wrap_d, (i == 3) ? 1 : 0);
      if (i == 2) check("seq_at_max", at_max_d, 1);
      step_d = 1'b0;
      tick();
      check("seq_wrap_clear", wrap_d, 0);
    end

    // held step: edge instance advances once, level instance ten times
    max_d = 10'd20;
    step_d = 1'b1; step_l = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("hold_edge", count_d, 1);
    check("hold_level", count_l, 10);
    check("hold_edge_wrap", wrap_d, 0);
    step_d = 1'b0; step_l = 1'b0;
    tick();

    // down from zero: wrap to max vs saturate at zero
    up = 1'b0; max_d = 10'd5; load_d = 1'b1; lv_d = 10'd0;
    tick();
    load_d = 1'b0;
    check("load0", count_d, 0);
    step_d = 1'b1; step_s = 1'b1;
    tick();
    check("down_wrap_count", count_d, 5);
    check("down_wrap_pulse", wrap_d, 1);
    check("sat_down_count", count_s, 0);
    check("sat_down_pulse", wrap_s, 1);
    step_d = 1'b0; step_s = 1'b0;
    tick();
    check("down_wrap_clear", wrap_d, 0);
    up = 1'b1; load_s = 1'b1; lv_s = 10'd5;
    tick();
    load_s = 1'b0; step_s = 1'b1;
    tick();
    check("sat_up_count", count_s, 5);
    check("sat_up_pulse", wrap_s, 1);
    step_s = 1'b0;
    tick();

    // load clamps to max and beats a simultaneous step edge
    max_d = 10'd9; load_d = 1'b1; lv_d = 10'd7;
    tick();
    check("load7", count_d, 7);
    lv_d = 10'd900; step_d = 1'b1;
    tick();
    check("load_clamp", count_d, 9);
    check("load_clamp_wrap", wrap_d, 0);
    load_d = 1'b0; step_d = 1'b0;
    tick();

    // max lowered below count
    lv_d = 10'd8; load_d = 1'b1;
    tick();
    load_d = 1'b0; max_d = 10'd4;
    tick();
    check("lowered_hold", count_d, 8);
    check("lowered_at_max", at_max_d, 0);
    step_d = 1'b1;
    tick();
    check("lowered_up_count", count_d, 0);
    check("lowered_up_wrap", wrap_d, 1);
    step_d = 1'b0; max_d = 10'd9; load_d = 1'b1;
    tick();
    load_d = 1'b0; max_d = 10'd4; up = 1'b0;
    tick();
    step_d = 1'b1;
    tick();
    check("lowered_dn_count", count_d, 4);
    check("lowered_dn_wrap", wrap_d, 0);
    step_d = 1'b0;
    tick();
    step_d = 1'b1;
    tick();
    check("dn_normal", count_d, 3);
    step_d = 1'b0;
    tick();

    // max = 0: count pinned at zero, every step pulses wrap
    max_d = 10'd0; lv_d = 10'd0; load_d = 1'b1;
    tick();
    load_d = 1'b0; up = 1'b1; step_d = 1'b1;
    tick();
    check("max0_up_count", count_d, 0);
    check("max0_up_wrap", wrap_d, 1);
    step_d = 1'b0;
    tick();
    up = 1'b0; step_d = 1'b1;
    tick();
    check("max0_dn_count", count_d, 0);
    check("max0_dn_wrap", wrap_d, 1);
    step_d = 1'b0; up = 1'b1;
    tick();

    // reset with step held high: needs a fresh rising edge afterwards
    max_d = 10'd9; lv_d = 10'd6; load_d = 1'b1; step_d = 1'b1;
    tick();
    check("pre_rst_count", count_d, 6);
    load_d = 1'b0; reset = 1'b1;
    tick();
    check("rst_mid_count", count_d, 0);
    check("rst_mid_wrap", wrap_d, 0);
    reset = 1'b0;
    tick();
    tick();
    check("rst_held_step", count_d, 0);
    step_d = 1'b0;
    tick();
    step_d = 1'b1;
    tick();
    check("rst_new_edge", count_d, 1);
    step_d = 1'b0;
    tick();

    // a limit event coinciding with reset leaves no wrap behind
    lv_d = 10'd9; load_d = 1'b1;
    tick();
    load_d = 1'b0; step_d = 1'b1; reset = 1'b1;
    tick();
    check("rst_vs_wrap_count", count_d, 0);
    check("rst_vs_wrap_pulse", wrap_d, 0);
    reset = 1'b0;
    tick();
    check("rst_release_wrap", wrap_d, 0);
    step_d = 1'b0;
    tick();

    // 16-bit all-ones limit
    up = 1'b1; lv_w = 16'd65534; load_w = 1'b1;
    tick();
    load_w = 1'b0; step_w = 1'b1;
    tick();
    check("w16_top", count_w, 65535);
    check("w16_at_max", at_max_w, 1);
    check("w16_top_wrap", wrap_w, 0);
    step_w = 1'b0;
    tick();
    step_w = 1'b1;
    tick();
    check("w16_roll_count", count_w, 0);
    check("w16_roll_wrap", wrap_w, 1);
    step_w = 1'b0;
    tick();
    up = 1'b0; step_w = 1'b1;
    tick();
    check("w16_under_count", count_w, 65535);
    check("w16_under_wrap", wrap_w, 1);
    step_w = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wrap_counter.md
WRAP_COUNTER -- requirements
Module: wrap_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 10: bit width of count, max and load_value (legal 2..16).
REQ-002 SHALL have parameter EDGE_MODE, default 1: 1 = step counts on rising edge only; 0 = step is a level enable, counting every cycle it is high.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap at limits; 1 = hold at limits.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port step  input  1  count request, already debounced/synchronous to clock.
REQ-007 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 SHALL have port load  input  1  synchronous load strobe.
REQ-009 SHALL have port load_value  input  WIDTH  value loaded on load.
REQ-010 SHALL have port max  input  WIDTH  inclusive upper count limit; may change at any time.
REQ-011 SHALL have port count  output  WIDTH  registered current count.
REQ-012 SHALL have port wrap  output  1  registered one-cycle pulse marking a limit event.
REQ-013 SHALL have port at_max  output  1  combinational flag, high when count == max.

Function
REQ-014 SHALL define an accepted step ("adv") as step & ~step_q when EDGE_MODE=1, and as step when EDGE_MODE=0; step_q is step registered every cycle.
REQ-015 SHALL update count on the same rising edge at which adv is sampled high (zero added latency).
REQ-016 SHALL keep count in the inclusive range 0..max; modulus is max+1.
REQ-017 SHALL, on adv with up=1 and count < max, set count = count+1 and wrap = 0.
REQ-018 SHALL, on adv with up=1 and count >= max, set count = 0 (SATURATE=0) or max (SATURATE=1), with wrap = 1 in both cases.
REQ-019 SHALL, on adv with up=0 and 0 < count <= max, set count = count-1 and wrap = 0.
REQ-020 SHALL, on adv with up=0 and count == 0, set count = max (SATURATE=0) or 0 (SATURATE=1), with wrap = 1 in both cases.
REQ-021 SHALL, on adv with up=0 and count > max (max lowered at run time), set count = max and wrap = 0.
REQ-022 SHALL, on load, set count = min(load_value, max) and wrap = 0; load has priority over adv in the same cycle.
REQ-023 SHALL hold count and drive wrap = 0 in any cycle with no adv and no load.
REQ-024 SHALL handle max = 0 as: count stays 0, and wrap pulses on every adv.
REQ-025 SHALL perform all arithmetic in WIDTH bits, with no carry or borrow escaping; overflow at all-ones max SHALL follow REQ-018.
REQ-026 SHALL update at_max combinationally from the current count and max.

Reset
REQ-027 SHALL, while reset is sampled high, set count = 0, wrap = 0 and step_q = 1, with reset priority over load and adv.
REQ-028 SHALL not count a step held high across reset release when EDGE_MODE=1; a new rising edge is required.
REQ-029 SHALL abandon any in-progress edge or pulse on reset asserted mid-operation, with no residual wrap after release.

Verification
REQ-030 Defaults, max=3, up=1, four isolated step pulses -> count 1,2,3,0; wrap high only in the cycle count becomes 0.
REQ-031 EDGE_MODE=1, step held high 10 cycles -> count advances exactly once; EDGE_MODE=0, same stimulus, max=20 -> count advances 10.
REQ-032 up=0 from count=0, max=5 -> count 5 with wrap pulse; with SATURATE=1 -> count stays 0 with wrap pulse.
REQ-033 count=7, load=1, load_value=900, max=9, step edge in the same cycle -> count 9, wrap 0.
REQ-034 count=8, max lowered to 4 -> next up step gives 0 with wrap=1; next down step (from a separate count=8 case) gives 4 with wrap=0.
REQ-035 reset pulsed with step high and count=6 -> count 0, wrap 0; no count until step falls and rises again; WIDTH=16, max=65535 wrap-around is also checked.
